// File: rtl/wt_dcache_inval_queue.sv
// Invalidation request queue: buffers (base line, line count) requests from the bus and
// replays them one line at a time to the dcache invalidation unit. Optional macro: WT_DCACHE_INVQ_PERF_EN.
module wt_dcache_inval_queue #(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned LINE_OFF_W = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  bus_inv_vld_i,
    output logic                  bus_inv_rdy_o,
    input  logic [PLEN-1:0]       bus_inv_paddr_i,
    input  logic [CNT_W-1:0]      bus_inv_nlines_i,
    output logic                  bus_inv_done_o,
    output logic                  mem_inv_req_vld_o,
    output logic [PLEN-1:0]       mem_inv_paddr_o,
    input  logic                  mem_inv_ack_i,
    output logic                  busy_o
`ifdef WT_DCACHE_INVQ_PERF_EN
    ,
    output logic [31:0]           perf_lines_o
`endif
);

    localparam int unsigned LINE_W = PLEN - LINE_OFF_W;
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    // state    | meaning
    // ST_EMPTY | nothing to issue, request valid low
    // ST_ISSUE | presenting head line (base + line_cnt_q) to the inval unit
    typedef enum logic {
        ST_EMPTY,
        ST_ISSUE
    } state_e;

    state_e state_q, state_d;

    logic [PTR_W:0]      wr_ptr_q, rd_ptr_q, rd_ptr_inc;
    logic [LINE_W-1:0]   line_mem_q   [DEPTH];
    logic [CNT_W-1:0]    nlines_mem_q [DEPTH];
    logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
    logic                done_q;

    logic                empty, full, push, pop, fire, last_line, empty_after_pop;
    logic [LINE_W-1:0]   head_line, line_addr;
    logic [CNT_W-1:0]    head_nlines;
    logic                unused_offset;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);

    assign bus_inv_rdy_o = ~full;
    assign push          = bus_inv_vld_i & ~full;

    assign head_line   = line_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_nlines = nlines_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign last_line   = (line_cnt_q == head_nlines);

    // Line index wraps inside the line-address field; nothing carries past it.
    assign line_addr   = head_line + LINE_W'(line_cnt_q);

    assign fire = (state_q == ST_ISSUE) & mem_inv_ack_i;
    assign pop  = fire & last_line;

    assign rd_ptr_inc      = rd_ptr_q + 1'b1;
    assign empty_after_pop = (rd_ptr_inc == wr_ptr_q) & ~push;

    // Byte offset is meaningless for a line invalidation.
    assign unused_offset = ^bus_inv_paddr_i[LINE_OFF_W-1:0];

    always_ff @(posedge clk_i) begin
        if (push) begin
            line_mem_q[wr_ptr_q[PTR_W-1:0]]   <= bus_inv_paddr_i[PLEN-1:LINE_OFF_W];
            nlines_mem_q[wr_ptr_q[PTR_W-1:0]] <= bus_inv_nlines_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            line_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            done_q     <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_inc;
        end
    end

    always_comb begin
        state_d           = state_q;
        line_cnt_d        = line_cnt_q;
        mem_inv_req_vld_o = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                // Entering on the push itself gives the one-cycle bus-to-mem latency.
                if (!empty || push) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_inv_req_vld_o = 1'b1;
                if (mem_inv_ack_i) begin
                    if (last_line) begin
                        line_cnt_d = '0;
                        if (empty_after_pop) state_d = ST_EMPTY;
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign mem_inv_paddr_o = mem_inv_req_vld_o ? {line_addr, {LINE_OFF_W{1'b0}}} : '0;
    assign bus_inv_done_o  = done_q;
    assign busy_o          = ~empty | done_q;

`ifdef WT_DCACHE_INVQ_PERF_EN
    logic [31:0] perf_lines_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_lines_q <= '0;
        end else if (fire && (perf_lines_q != 32'hFFFF_FFFF)) begin
            perf_lines_q <= perf_lines_q + 32'd1;
        end
    end

    assign perf_lines_o = perf_lines_q;
`endif

endmodule
